// File: rtl/jacaranda_int_ctrl.sv
// jacaranda_int_ctrl - priority interrupt controller for the jacaranda-8.
//
// Collects up to eight rising-edge interrupt sources and shares the CPU's
// single interrupt request line between them. Source 0 has the highest
// priority. There is no nesting: one source is in flight from request until
// software writes end-of-interrupt. Edges arriving meanwhile accumulate in PEND.
//
// Register map (BASE_ADDR + offset):
//   +0 PEND  : pending bits, write-1-to-clear
//   +1 MASK  : enable bits, 1 = enabled
//   +2 STAT  : {in_service, requesting, 3'b0, id[2:0]}; any write is EOI
//   +3 VBASE : vector base; int_vec = VBASE + 4*id (8-bit wrap-around)
// Bits at or above NSRC read as 0 and ignore writes.
//
// Configuration macro: INTC_SYNC_EN
//   defined   - each src bit passes through a 2-flop synchronizer before edge
//               detection (asynchronous pads); adds 2 cycles of latency.
//   undefined - src feeds edge detection directly and must be synchronous.
//
// Ports:
//   clock    in  : system clock, rising edge
//   reset    in  : synchronous, active-high
//   src      in  : NSRC interrupt sources, rising-edge sensitive
//   addr     in  : data-bus address
//   w_data   in  : write data
//   w_en     in  : write strobe
//   r_data   out : combinational read data, 0 when the address is not ours
//   r_hit    out : combinational, high when addr is in BASE..BASE+3
//   int_ack  in  : one-cycle pulse when the CPU vectors to int_vec
//   int_req  out : registered interrupt request
//   int_vec  out : registered handler address, valid while int_req is high

module jacaranda_int_ctrl #(
    parameter int          NSRC      = 4,
    parameter logic [7:0]  BASE_ADDR = 8'd244
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [7:0]      addr,
    input  logic [7:0]      w_data,
    input  logic            w_en,
    output logic [7:0]      r_data,
    output logic            r_hit,
    input  logic            int_ack,
    output logic            int_req,
    output logic [7:0]      int_vec
);

    // Bits that correspond to implemented sources.
    localparam logic [7:0] SRC_VALID = 8'((16'd1 << NSRC) - 16'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      state_r;
    logic [7:0]  pend_r;
    logic [7:0]  mask_r;
    logic [7:0]  vbase_r;
    logic [2:0]  id_r;
    logic [7:0]  src_q_r;

    logic [7:0]  src_ext_s;
    logic [7:0]  src_s;
    logic [7:0]  rise_s;
    logic [7:0]  offset_s;
    logic        hit_s;
    logic        wr_pend_s;
    logic        wr_mask_s;
    logic        wr_eoi_s;
    logic        wr_vbase_s;
    logic        ack_fire_s;
    logic [7:0]  clr_s;
    logic [7:0]  arb_s;
    logic [2:0]  arb_id_s;
    logic [7:0]  rd_s;

    // Index of the lowest set bit (highest priority); 0 when none are set.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Zero-extend the source vector to the 8-bit register width.
    always_comb begin
        src_ext_s = 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            src_ext_s[i] = src[i];
        end
    end

`ifdef INTC_SYNC_EN
    logic [7:0] sync1_r;
    logic [7:0] sync2_r;

    // Two-flop synchronizer for asynchronous source pads.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 8'h00;
            sync2_r <= 8'h00;
        end else begin
            sync1_r <= src_ext_s;
            sync2_r <= sync1_r;
        end
    end

    assign src_s = sync2_r;
`else
    assign src_s = src_ext_s;
`endif

    // Address decode; BASE_ADDR <= 252 keeps BASE+3 inside the 8-bit space.
    always_comb begin
        offset_s   = addr - BASE_ADDR;
        hit_s      = (addr >= BASE_ADDR) && (offset_s < 8'd4);
        wr_pend_s  = w_en && hit_s && (offset_s[1:0] == 2'd0);
        wr_mask_s  = w_en && hit_s && (offset_s[1:0] == 2'd1);
        wr_eoi_s   = w_en && hit_s && (offset_s[1:0] == 2'd2);
        wr_vbase_s = w_en && hit_s && (offset_s[1:0] == 2'd3);
    end

    // Edge detect, clear sources and arbitration inputs.
    always_comb begin
        rise_s     = src_s & ~src_q_r & SRC_VALID;
        ack_fire_s = (state_r == ST_REQ) && int_ack;
        clr_s      = 8'h00;
        if (wr_pend_s) begin
            clr_s = clr_s | w_data;
        end else begin
            clr_s = clr_s;
        end
        if (ack_fire_s) begin
            clr_s = clr_s | (8'h01 << id_r);
        end else begin
            clr_s = clr_s;
        end
        arb_s    = pend_r & mask_r;
        arb_id_s = lowest_idx(arb_s);
    end

    // Combinational register read mux.
    always_comb begin
        rd_s = 8'h00;
        if (hit_s) begin
            case (offset_s[1:0])
                2'd0:    rd_s = pend_r;
                2'd1:    rd_s = mask_r;
                2'd2:    rd_s = {(state_r == ST_SERVICE), (state_r == ST_REQ), 3'b000, id_r};
                2'd3:    rd_s = vbase_r;
                default: rd_s = 8'h00;
            endcase
        end else begin
            rd_s = 8'h00;
        end
    end

    assign r_data = rd_s;
    assign r_hit  = hit_s;

    // Pending, mask and vector-base registers plus the previous source sample.
    // A new edge is OR-ed in after the clears so that a coincident set wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_r  <= 8'h00;
            mask_r  <= 8'h00;
            vbase_r <= 8'h00;
            src_q_r <= 8'h00;
        end else begin
            src_q_r <= src_s;
            pend_r  <= ((pend_r & ~clr_s) | rise_s) & SRC_VALID;
            if (wr_mask_s) begin
                mask_r <= w_data & SRC_VALID;
            end
            if (wr_vbase_s) begin
                vbase_r <= w_data;
            end
        end
    end

    // Request/service state machine with registered int_req and int_vec.
    // The id is latched on REQ entry and never re-arbitrated before the ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            id_r    <= 3'd0;
            int_req <= 1'b0;
            int_vec <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arb_s != 8'h00) begin
                        state_r <= ST_REQ;
                        id_r    <= arb_id_s;
                        int_vec <= vbase_r + {3'b000, arb_id_s, 2'b00};
                        int_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_r <= ST_SERVICE;
                        int_req <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (wr_eoi_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jacaranda_int_ctrl.sv
// Self-checking bench for jacaranda_int_ctrl (NSRC=4, BASE=8'hF4).
// Each table row is driven on the falling edge; outputs are compared 1 time
// unit later, i.e. they reflect state after the previous rising edge, then
// the row's inputs are captured on the next rising edge.
// Register addresses: F4 PEND, F5 MASK, F6 STAT, F7 VBASE.

module tb_jacaranda_int_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] src;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       r_hit;
    logic       int_ack;
    logic       int_req;
    logic [7:0] int_vec;

    int n_cmp;
    int n_miss;

    jacaranda_int_ctrl #(.NSRC(4), .BASE_ADDR(8'd244)) dut (
        .clock   (clock),
        .reset   (reset),
        .src     (src),
        .addr    (addr),
        .w_data  (w_data),
        .w_en    (w_en),
        .r_data  (r_data),
        .r_hit   (r_hit),
        .int_ack (int_ack),
        .int_req (int_req),
        .int_vec (int_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] src;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       we;
        logic       ack;
        logic [7:0] e_rd;
        logic       e_hit;
        logic       e_req;
        logic [7:0] e_vec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] s, input logic [7:0] a,
                       input logic [7:0] wd, input logic we, input logic ack,
                       input logic [7:0] erd, input logic ehit, input logic ereq,
                       input logic [7:0] evec);
        vec_t v;
        v.rst = rst; v.src = s; v.addr = a; v.wd = wd; v.we = we; v.ack = ack;
        v.e_rd = erd; v.e_hit = ehit; v.e_req = ereq; v.e_vec = evec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        n_cmp = 0; n_miss = 0;
        reset = 1'b1; src = 4'h0; addr = 8'h00; w_data = 8'h00; w_en = 1'b0; int_ack = 1'b0;

        //     rst src addr   wd     we   ack   rd     hit   req   vec
        // Basic request: MASK=0F, VBASE=80, pulse src[2]; id 2 -> 80 + 8 = 88.
        add(1'b0, 4'h0, 8'hF5, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF7, 8'h80, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h4, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 1'b1, 8'h88);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h88);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b1, 1'b0, 8'h82, 1'b1, 1'b0, 8'h88);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 8'h88);
        // Priority: src[3] and src[1] together -> id 1 (84), then id 3 (8C).
        add(1'b0, 4'hA, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h88);
        add(1'b0, 4'hA, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 8'h88);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 8'h84);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 8'h84);
        add(1'b0, 4'h0, 8'hF6, 8'hFF, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 8'h84);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h84);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b1, 8'h43, 1'b1, 1'b1, 8'h8C);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0, 8'h8C);
        // Masking: MASK=0, edge on src[0] stays pending until MASK=01.
        add(1'b0, 4'h0, 8'hF5, 8'h00, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h8C);
        add(1'b0, 4'h1, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h8C);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h8C);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h8C);
        add(1'b0, 4'h0, 8'hF5, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h8C);
        add(1'b0, 4'h0, 8'hF5, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h8C);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 8'h80);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80);
        // Simultaneous W1C and new edge on bit 0: set wins; plain W1C clears.
        add(1'b0, 4'h0, 8'hF5, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h1, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h1, 8'hF4, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h1, 8'hF4, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h1, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80);
        // Wrap-around (FC + 4 = 00) and stray EOI in IDLE / REQ, ack in SERVICE.
        add(1'b0, 4'h0, 8'hF7, 8'hFC, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h0, 8'hF5, 8'h02, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h2, 8'hF6, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h2, 8'hF6, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h00);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b0, 8'h41, 1'b1, 1'b1, 8'h00);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 8'h00);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h1, 8'hF6, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00);
        // Reset in SERVICE with bit 0 pending; everything returns to zero.
        add(1'b1, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF6, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        // Address window edges and unimplemented mask bits.
        add(1'b0, 4'h0, 8'hF8, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF5, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        add(1'b0, 4'h0, 8'hF5, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00);

        repeat (2) @(posedge clock);

        foreach (tbl[i]) begin
            @(negedge clock);
            reset = tbl[i].rst; src = tbl[i].src; addr = tbl[i].addr;
            w_data = tbl[i].wd; w_en = tbl[i].we; int_ack = tbl[i].ack;
            #1;
            chk($sformatf("row%0d r_data", i), r_data, tbl[i].e_rd);
            chk($sformatf("row%0d r_hit", i), {7'd0, r_hit}, {7'd0, tbl[i].e_hit});
            chk($sformatf("row%0d int_req", i), {7'd0, int_req}, {7'd0, tbl[i].e_req});
            chk($sformatf("row%0d int_vec", i), int_vec, tbl[i].e_vec);
        end

        // Source-to-request latency: VBASE=10, edge on src[3] -> vector 1C.
        @(negedge clock);
        reset = 1'b0; src = 4'h0; addr = 8'hF7; w_data = 8'h10; w_en = 1'b1; int_ack = 1'b0;
        @(negedge clock);
        w_en = 1'b0; addr = 8'hF6; src = 4'h8;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            src = 4'h0;
            #1;
            if (int_req) begin
                lat = c;
                break;
            end
        end
        chk("latency", 8'(lat), 8'd2);
        chk("lat int_vec", int_vec, 8'h1C);
        chk("lat stat", r_data, 8'h43);

        // Reset while requesting: request drops, pending bit 3 discarded.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst int_req", {7'd0, int_req}, 8'd0);
        chk("rst int_vec", int_vec, 8'h00);
        chk("rst stat", r_data, 8'h00);
        addr = 8'hF4;
        #1;
        chk("rst pend", r_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
